// File: rtl/alu_pipe.sv
// Pipelined RV32I/M integer execution unit: combinational execute, STAGES result
// registers, valid/ready handshake to the CDB, flush on mispredict.
module alu_pipe #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2,
  parameter int EN_MUL = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_res,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam int         SH_W       = $clog2(XLEN);

  logic            adv;
  logic            accept;
  logic [XLEN-1:0] op2;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_res;
  logic            br_cond;
  logic [XLEN-1:0] c_res;
  logic            c_taken;
  logic [XLEN-1:0] c_target;

  assign adv      = rdy_in & (~out_valid | out_ready);
  assign in_ready = adv & ~flush;
  assign accept   = in_valid & in_ready;

  // OP-IMM reuses the register ALU with the immediate as the second operand.
  assign op2   = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (in_funct3)
      3'd0: alu_res = ((in_opcode == OPC_OP) && in_funct7[5]) ? in_rs1 - op2 : in_rs1 + op2;
      3'd1: alu_res = in_rs1 << shamt;
      3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(op2))};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < op2)};
      3'd4: alu_res = in_rs1 ^ op2;
      3'd5: alu_res = in_funct7[5] ? XLEN'($signed(in_rs1) >>> shamt) : in_rs1 >> shamt;
      3'd6: alu_res = in_rs1 | op2;
      default: alu_res = in_rs1 & op2;
    endcase
  end

  generate
    if (EN_MUL != 0) begin : g_mul
      logic [2*XLEN-1:0] a_w;
      logic [2*XLEN-1:0] b_w;
      logic [2*XLEN-1:0] prod;
      // Extending both operands to 2*XLEN makes an unsigned multiply yield
      // the right signed/unsigned product modulo 2^(2*XLEN).
      always_comb begin
        a_w = ((in_funct3 == 3'd1) || (in_funct3 == 3'd2)) ?
              {{XLEN{in_rs1[XLEN-1]}}, in_rs1} : {{XLEN{1'b0}}, in_rs1};
        b_w = (in_funct3 == 3'd1) ?
              {{XLEN{in_rs2[XLEN-1]}}, in_rs2} : {{XLEN{1'b0}}, in_rs2};
        prod = a_w * b_w;
        mul_res = '0;
        if (in_funct3 == 3'd0)
          mul_res = prod[XLEN-1:0];
        else if (in_funct3 <= 3'd3)
          mul_res = prod[2*XLEN-1:XLEN];
      end
    end else begin : g_no_mul
      assign mul_res = '0;
    end
  endgenerate

  always_comb begin
    br_cond = 1'b0;
    case (in_funct3)
      3'd0: br_cond = (in_rs1 == in_rs2);
      3'd1: br_cond = (in_rs1 != in_rs2);
      3'd4: br_cond = ($signed(in_rs1) <  $signed(in_rs2));
      3'd5: br_cond = ($signed(in_rs1) >= $signed(in_rs2));
      3'd6: br_cond = (in_rs1 <  in_rs2);
      3'd7: br_cond = (in_rs1 >= in_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    c_res    = '0;
    c_taken  = 1'b0;
    c_target = '0;
    case (in_opcode)
      OPC_OP:     c_res = (in_funct7 == F7_MULDIV) ? mul_res : alu_res;
      OPC_OP_IMM: c_res = alu_res;
      OPC_LUI:    c_res = in_imm;
      OPC_AUIPC:  c_res = in_pc + in_imm;
      OPC_JAL: begin
        c_res    = in_pc + XLEN'(4);
        c_target = in_pc + in_imm;
      end
      OPC_JALR: begin
        c_res    = in_pc + XLEN'(4);
        c_target = (in_rs1 + in_imm) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        c_taken  = br_cond;
        c_target = in_pc + in_imm;
      end
      default: ;
    endcase
  end

  // Result shift register; stage 0 takes the execute result, stage gi its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             v_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [XLEN-1:0]  res_reg;
      logic             taken_reg;
      logic [XLEN-1:0]  target_reg;
      logic             s_v;
      logic [TAG_W-1:0] s_tag;
      logic [XLEN-1:0]  s_res;
      logic             s_taken;
      logic [XLEN-1:0]  s_target;

      if (gi == 0) begin : g_src
        assign s_v      = accept;
        assign s_tag    = in_tag;
        assign s_res    = c_res;
        assign s_taken  = c_taken;
        assign s_target = c_target;
      end else begin : g_src
        assign s_v      = g_stage[gi-1].v_reg;
        assign s_tag    = g_stage[gi-1].tag_reg;
        assign s_res    = g_stage[gi-1].res_reg;
        assign s_taken  = g_stage[gi-1].taken_reg;
        assign s_target = g_stage[gi-1].target_reg;
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          v_reg      <= 1'b0;
          tag_reg    <= '0;
          res_reg    <= '0;
          taken_reg  <= 1'b0;
          target_reg <= '0;
        end else if (rdy_in) begin
          if (flush) begin
            v_reg <= 1'b0;
          end else if (adv) begin
            v_reg      <= s_v;
            tag_reg    <= s_tag;
            res_reg    <= s_res;
            taken_reg  <= s_taken;
            target_reg <= s_target;
          end
        end
      end
    end
  endgenerate

  assign out_valid  = g_stage[STAGES-1].v_reg;
  assign out_tag    = g_stage[STAGES-1].tag_reg;
  assign out_res    = g_stage[STAGES-1].res_reg;
  assign out_taken  = g_stage[STAGES-1].taken_reg;
  assign out_target = g_stage[STAGES-1].target_reg;

endmodule
